// File: rtl/matrix_log_search_pkg.sv
// Shared definitions for the matrix discrete-log search: FSM encoding and the
// flat-matrix packing (row-major, flat index 0 is row 0 col 0).
package matrix_log_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Flat index of element (r, c) in an n x n matrix declared as [0:n*n-1].
  function automatic int mat_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/identity_matrix.sv
// Constant N x N identity matrix in the shared flat packing.
module identity_matrix
  import matrix_log_search_pkg::*;
#(
  parameter int N = 4
) (
  output logic [0:N*N-1] m
);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign m[mat_idx(r, c, N)] = (r == c);
    end
  end

endmodule

// File: rtl/matrix_mul.sv
// Combinational boolean matrix product p = a * b (AND for product, OR for sum).
module matrix_mul
  import matrix_log_search_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [0:N*N-1] a,
  input  logic [0:N*N-1] b,
  output logic [0:N*N-1] p
);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [N-1:0] terms;
      for (genvar k = 0; k < N; k++) begin : g_term
        assign terms[k] = a[mat_idx(r, k, N)] & b[mat_idx(k, c, N)];
      end
      assign p[mat_idx(r, c, N)] = |terms;
    end
  end

endmodule

// File: rtl/matrix_log_search.sv
// Finds the smallest e in 0..2^K-1 with A^e == T by stepping an accumulator
// through I, A, A^2, ... one multiply per cycle.
module matrix_log_search
  import matrix_log_search_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [0:N*N-1] in_base,
  input  logic [0:N*N-1] in_target,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [K-1:0]   out_exp
);

  localparam int NN = N * N;
  localparam logic [K-1:0] E_MAX = '1;

  state_e          state_q, state_d;
  logic [0:NN-1]   a_q, a_d;
  logic [0:NN-1]   t_q, t_d;
  logic [0:NN-1]   acc_q, acc_d;
  logic [K-1:0]    e_q, e_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            found_q, found_d;
  logic [K-1:0]    exp_q, exp_d;

  logic [0:NN-1]   ident;
  logic [0:NN-1]   prod;

  identity_matrix #(.N(N)) u_ident (.m(ident));

  matrix_mul #(.N(N)) u_mul (
    .a (acc_q),
    .b (a_q),
    .p (prod)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    t_d     = t_q;
    acc_d   = acc_q;
    e_d     = e_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    exp_d   = exp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = in_base;
          t_d     = in_target;
          acc_d   = ident;
          e_d     = '0;
          busy_d  = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        // Match is checked first so T = I resolves at e = 0, and an orbit that
        // closes exactly on T still reports the match.
        if (acc_q == t_q) begin
          found_d = 1'b1;
          exp_d   = e_q;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if ((e_q != '0 && acc_q == ident) || e_q == E_MAX) begin
          found_d = 1'b0;
          exp_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_d = prod;
          e_d   = e_q + K'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      e_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      exp_q   <= exp_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign out_exp = exp_q;

endmodule

// File: doc/matrix_log_search.md
Name: matrix_log_search

Overview:
- Inverse of the combinational matrix power block: given base matrix A and target matrix T, finds the smallest exponent e, 0 <= e <= 2^K-1, such that A^e == T.
- Iterative and sequential: an accumulator starts at the identity matrix and is multiplied by A once per cycle, using one combinational matrix_mul instance.
- Sits beside the power unit in the switching-generator datapath, for recovering step counts from generated state matrices.

Parameters:
- N, 4, matrix dimension; matrices are flat N*N-bit vectors, row-major, bit 0 is row 0 col 0 (same packing as matrix_mul).
- K, 8, exponent width; search range is 0..2^K-1.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- in_base  input  [0:N*N-1]  base matrix A; sampled on the accepted start.
- in_target  input  [0:N*N-1]  target matrix T; sampled on the accepted start.
- busy  output  1  high in SEARCH and DONE.
- done  output  1  one-cycle pulse when the result is valid.
- found  output  1  1 = match found; valid from done, held until the next done.
- out_exp  output  [K-1:0]  matching exponent; 0 when found=0; held like found.

Behaviour:
- Clock and reset: one clock domain. rst is synchronous and active-high. It forces IDLE and clears busy, done, found, out_exp, the accumulator (acc) and the exponent counter (e) to 0. Reset mid-search aborts with no done pulse.
- All outputs are registered.
- IDLE:
  - start=1 in cycle t latches A and T, sets acc to the identity matrix and e to 0, and enters SEARCH at t+1.
  - start=0 stays in IDLE.
- SEARCH: one comparison per cycle, evaluated in this priority order:
  1. acc == T: set found=1, out_exp=e, go to DONE.
  2. Else e != 0 and acc == identity (orbit closed without a match): set found=0, out_exp=0, go to DONE.
  3. Else e == 2^K-1 (range exhausted): set found=0, out_exp=0, go to DONE.
  4. Else acc <= matrix_mul(acc, A) and e <= e+1, stay in SEARCH.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in that same following cycle.
- Latency: start accepted at cycle t, decision at exponent e, so done is high in cycle t+e+2. Worst case is t+2^K+1.
- start while busy: ignored, not queued. in_base/in_target changes after acceptance have no effect.
- start coincident with rst: rst wins, request dropped.
- e never wraps: termination at 2^K-1 precedes any increment.
- Multiplication semantics are exactly those of the shared matrix_mul. Only one multiplier instance exists (area target).
- A = zero matrix: acc becomes zero at e=1 and never returns to identity, so the search ends by match (T = 0 gives e=1) or by exhaustion.

Decomposition:
- Shared package or include: state encoding (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2) and the flat-matrix packing convention.
- Reuse existing identity_matrix #(N) for the identity constant and matrix_mul #(N) for the step product.
- No new sub-module; the FSM, acc/e registers and the equality comparators live in matrix_log_search.

Test Plan:
All cases use N=4, K=8 unless noted. P = cyclic-shift permutation (row i has its 1 in column (i+1) mod 4), order 4. Permutation operands are used so results are independent of the multiplier's semiring.
- Match at exponent 3: A=P, T=P^3, start at t -> done at t+5, found=1, out_exp=3, busy high t+1..t+5.
- Identity target: A=P, T=identity -> done at t+2, found=1, out_exp=0.
- Orbit closure: A=P, T=all-zeros -> the e=4 identity-return rule fires; done at t+6, found=0, out_exp=0.
- Exhaustion: N=5, K=2, A = 5-cycle shift, T=all-zeros -> e reaches 3 with no match; done at t+5, found=0.
- Start while busy: second start with T=P^1 at t+2 during the first search -> ignored; the first result (out_exp=3) is reported and exactly one done pulse occurs.
- Reset mid-search: rst at t+3 -> next cycle busy=0, found=0, out_exp=0, no done. A new start then completes normally.
